// File: rtl/sme_job_feeder_if.sv
// Host byte stream, SME strobe/result and host result handshake of the SME job feeder.
// Widths are fixed by the SME: 8-bit chars, 5-bit match index.
interface sme_job_feeder_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [1:0] in_type;
  logic       in_last;
  logic [7:0] chardata;
  logic       isstring;
  logic       ispattern;
  logic       sme_valid;
  logic       sme_match;
  logic [4:0] sme_index;
  logic       res_valid;
  logic       res_ready;
  logic       res_match;
  logic [4:0] res_index;
  logic       res_err;
  logic       busy;

  modport slave (
    input  in_valid, in_data, in_type, in_last, sme_valid, sme_match, sme_index, res_ready,
    output in_ready, chardata, isstring, ispattern, res_valid, res_match, res_index, res_err, busy
  );

  modport master (
    output in_valid, in_data, in_type, in_last, sme_valid, sme_match, sme_index, res_ready,
    input  in_ready, chardata, isstring, ispattern, res_valid, res_match, res_index, res_err, busy
  );
endinterface

// File: rtl/sme_job_feeder.sv
// Buffers one host job (optional string + pattern), replays it to the SME as
// back-to-back strobe bursts, waits for the verdict and hands it back to the host.
module sme_job_feeder #(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int TMO_CYC = 255
) (
  input logic             clk,
  input logic             reset,
  sme_job_feeder_if.slave bus
);

  localparam int SW = $clog2(STR_MAX + 1);
  localparam int SA = $clog2(STR_MAX);
  localparam int PW = $clog2(PAT_MAX + 1);
  localparam int PA = $clog2(PAT_MAX);

  typedef enum logic [2:0] {S_LOAD, S_SEND_S, S_SEND_P, S_WAIT, S_RESULT} state_t;

  state_t        r_state;
  logic [SW-1:0] r_s_len, r_s_idx;
  logic [PW-1:0] r_p_len, r_p_idx;
  logic          r_has_str, r_new_str, r_ovf;
  logic [7:0]    r_timer;
  logic [7:0]    r_chardata;
  logic          r_isstring, r_ispattern;
  logic          r_res_valid, r_res_match, r_res_err;
  logic [4:0]    r_res_index;
  logic [7:0]    r_str_buf [STR_MAX];
  logic [7:0]    r_pat_buf [PAT_MAX];

  logic          w_xfer, w_str_char, w_pat_char, w_str_full, w_pat_full;
  logic          w_str_we, w_pat_we, w_job_err;
  logic [SA-1:0] w_str_waddr;
  logic [7:0]    w_pat0;

  assign w_xfer      = bus.in_valid && (r_state == S_LOAD);
  assign w_str_char  = w_xfer && (bus.in_type == 2'd0);
  assign w_pat_char  = w_xfer && (bus.in_type == 2'd1);
  assign w_str_full  = (r_s_len == SW'(STR_MAX));
  assign w_pat_full  = (r_p_len == PW'(PAT_MAX));
  assign w_str_we    = w_str_char && (!r_new_str || !w_str_full);
  assign w_str_waddr = r_new_str ? r_s_len[SA-1:0] : '0;
  assign w_pat_we    = w_pat_char && !w_pat_full;
  assign w_job_err   = r_ovf || w_pat_full || (!r_new_str && !r_has_str);
  // A one-char pattern closes the job in the same cycle its char is written.
  assign w_pat0      = (r_p_len == '0) ? bus.in_data : r_pat_buf[0];

  // NOTE: buffer storage carries no reset; every entry is written before it is replayed.
  always_ff @(posedge clk) begin
    if (w_str_we) r_str_buf[w_str_waddr] <= bus.in_data;
    if (w_pat_we) r_pat_buf[r_p_len[PA-1:0]] <= bus.in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_LOAD;
      r_s_len     <= '0;
      r_s_idx     <= '0;
      r_p_len     <= '0;
      r_p_idx     <= '0;
      r_has_str   <= 1'b0;
      r_new_str   <= 1'b0;
      r_ovf       <= 1'b0;
      r_timer     <= '0;
      r_chardata  <= '0;
      r_isstring  <= 1'b0;
      r_ispattern <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_match <= 1'b0;
      r_res_index <= '0;
      r_res_err   <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_str_char) begin
            if (!r_new_str) begin
              r_new_str <= 1'b1;
              r_s_len   <= SW'(1);
            end else if (w_str_full) r_ovf <= 1'b1;
            else r_s_len <= r_s_len + SW'(1);
          end
          if (w_pat_char) begin
            if (w_pat_full) r_ovf <= 1'b1;
            else r_p_len <= r_p_len + PW'(1);
            if (bus.in_last) begin
              if (w_job_err) begin
                r_state     <= S_RESULT;
                r_res_valid <= 1'b1;
                r_res_err   <= 1'b1;
                r_res_match <= 1'b0;
                r_res_index <= '0;
              end else if (r_new_str) begin
                r_state    <= S_SEND_S;
                r_isstring <= 1'b1;
                r_chardata <= r_str_buf[0];
                r_s_idx    <= SW'(1);
              end else begin
                r_state     <= S_SEND_P;
                r_ispattern <= 1'b1;
                r_chardata  <= w_pat0;
                r_p_idx     <= PW'(1);
              end
            end
          end
        end
        S_SEND_S: begin
          r_has_str <= 1'b1;
          if (r_s_idx < r_s_len) begin
            r_chardata <= r_str_buf[r_s_idx[SA-1:0]];
            r_s_idx    <= r_s_idx + SW'(1);
          end else begin
            r_state     <= S_SEND_P;
            r_isstring  <= 1'b0;
            r_ispattern <= 1'b1;
            r_chardata  <= r_pat_buf[0];
            r_p_idx     <= PW'(1);
          end
        end
        S_SEND_P: begin
          if (r_p_idx < r_p_len) begin
            r_chardata <= r_pat_buf[r_p_idx[PA-1:0]];
            r_p_idx    <= r_p_idx + PW'(1);
          end else begin
            r_state     <= S_WAIT;
            r_ispattern <= 1'b0;
            r_chardata  <= '0;
            r_timer     <= '0;
          end
        end
        S_WAIT: begin
          if (bus.sme_valid) begin
            r_state     <= S_RESULT;
            r_res_valid <= 1'b1;
            r_res_match <= bus.sme_match;
            r_res_index <= bus.sme_index;
            r_res_err   <= 1'b0;
          end else if (r_timer == 8'(TMO_CYC - 1)) begin
            r_state     <= S_RESULT;
            r_res_valid <= 1'b1;
            r_res_match <= 1'b0;
            r_res_index <= '0;
            r_res_err   <= 1'b1;
          end else r_timer <= r_timer + 8'd1;
        end
        S_RESULT: begin
          if (bus.res_ready) begin
            r_state     <= S_LOAD;
            r_res_valid <= 1'b0;
            r_res_match <= 1'b0;
            r_res_index <= '0;
            r_res_err   <= 1'b0;
            r_p_len     <= '0;
            r_new_str   <= 1'b0;
            r_ovf       <= 1'b0;
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_LOAD);
  assign bus.busy      = (r_state != S_LOAD);
  assign bus.chardata  = r_chardata;
  assign bus.isstring  = r_isstring;
  assign bus.ispattern = r_ispattern;
  assign bus.res_valid = r_res_valid;
  assign bus.res_match = r_res_match;
  assign bus.res_index = r_res_index;
  assign bus.res_err   = r_res_err;

endmodule

// File: doc/sme_job_feeder.md
Name: sme_job_feeder

Overview:
- Upstream feeder for the string-matching engine (SME).
- Accepts a tagged byte stream from the host over a valid/ready handshake and buffers one job: an optional string plus a pattern.
- Replays the job to the SME as contiguous isstring/ispattern bursts, waits for the SME verdict, then returns it to the host over a result handshake.
- Admits exactly one job in flight.

Parameters:
STR_MAX, 32, string buffer depth in chars (SME string capacity)
PAT_MAX, 8, pattern buffer depth in chars (SME pattern capacity)
TMO_CYC, 255, WAIT-state cycles before a job is declared timed out

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
in_valid  in  1  host byte valid
in_ready  out  1  feeder accepts a byte this cycle
in_data  in  8  host byte
in_type  in  2  0=string char, 1=pattern char, 2/3=reserved
in_last  in  1  last pattern char; closes the job (ignored on other types)
chardata  out  8  char to SME
isstring  out  1  SME string strobe
ispattern  out  1  SME pattern strobe
sme_valid  in  1  SME result strobe
sme_match  in  1  SME match flag
sme_index  in  5  SME match index
res_valid  out  1  result available
res_ready  in  1  host takes result
res_match  out  1  match verdict
res_index  out  5  match position
res_err  out  1  job rejected (overflow, no string, or timeout)
busy  out  1  high in every state except LOAD

Behaviour:
- Reset:
  - Clears state to LOAD, all counters, has_str, ovf.
  - All outputs 0 except in_ready=1. Buffer contents need not be cleared.
  - Reset mid-operation abandons the job. SME strobes drop in the same cycle (async).
- Output timing: all SME-side and result outputs are registered. chardata=0 whenever no strobe is high.
- State LOAD (in_ready=1). A transfer occurs when in_valid & in_ready.
  - Type 0:
    - First type-0 char of a job resets s_len to 0 and sets new_str.
    - Char written to str_buf[s_len], s_len++.
    - If s_len already = STR_MAX: char dropped, ovf set.
  - Type 1:
    - Written to pat_buf[p_len], p_len++.
    - If p_len already = PAT_MAX: char dropped, ovf set.
    - If in_last, the job closes.
  - Type 2/3: consumed and discarded.
- Job close (cycle t), next-state decision:
  - ovf=1 -> RESULT with res_err=1.
  - Else new_str=0 and has_str=0 -> RESULT with res_err=1.
  - Else new_str=1 -> SEND_S.
  - Else -> SEND_P (string reuse: SME keeps its previous string).
  - First strobe appears at cycle t+1.
- SEND_S:
  - isstring=1 and chardata=str_buf[i] for i=0..s_len-1, one char per cycle, no gaps.
  - Sets has_str=1.
  - Cycle after the last string char goes straight to SEND_P; no idle cycle is allowed between bursts.
- SEND_P:
  - ispattern=1, chardata=pat_buf[j] for j=0..p_len-1, no gaps.
  - Then WAIT with both strobes 0.
- WAIT:
  - 8-bit timer starts at 0.
  - On sme_valid: latch sme_match/sme_index into res_match/res_index, res_err=0 -> RESULT.
  - If the timer reaches TMO_CYC with no sme_valid: res_err=1, res_match=0, res_index=0 -> RESULT.
  - sme_valid outside WAIT is ignored.
- RESULT:
  - res_valid=1; res_* held stable until res_ready.
  - In the cycle res_valid & res_ready: clear p_len, new_str, ovf -> LOAD.
  - res_valid drops the next cycle.
  - s_len and has_str persist across jobs for reuse.
- Error results always carry res_match=0, res_index=0.
- Minimum spacing: at least 2 cycles between sme_valid and the next SME strobe. This guarantees the SME has left its DONE state.

Test Plan:
1. String "ABCDE", pattern "CD" (last on D):
   - isstring 5 cycles A..E, then ispattern 2 cycles C,D, starting 1 cycle after close.
   - SME model returns match=1, index=2 -> res_valid, res_match=1, res_index=2, res_err=0.
2. Follow-up pattern-only job "E":
   - No isstring; ispattern 1 cycle 'E'.
   - SME returns index=4 -> res_match=1, res_index=4.
3. Pattern-only job "X" directly after reset:
   - No SME strobes ever; res_valid 1 cycle after close with res_err=1, res_match=0.
4. 33 string chars then pattern "A":
   - Char 33 dropped, no SME strobes, res_err=1.
   - Next valid job (new string "AB", pattern "B") -> index=1, res_err=0.
5. Valid job with the SME model never raising sme_valid:
   - res_valid with res_err=1 exactly TMO_CYC cycles after entering WAIT.
6. Result backpressure and reset:
   - res_ready held 0 for 10 cycles: res_* stable, in_ready=0, busy=1.
   - Reset asserted on the 3rd cycle of SEND_S: isstring=0 immediately; in_ready=1 after reset release.
